fetch_unit: RTL and testbench
=============================

FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 Parameter ADDR_WIDTH, default 64: fetch address width in bits.
REQ-002 Parameter LINE_WIDTH, default 64: memory word and queue input width in bits; a multiple of 8.
REQ-003 Parameter RESET_PC, default 0: byte address fetched first after reset.
REQ-004 Port clk, input, 1: single clock; all state updates on its rising edge.
REQ-005 Port reset, input, 1: asynchronous, active-low reset.
REQ-006 Port redirect, input, 1: branch/jump redirect request, sampled each cycle.
REQ-007 Port redirect_pc, input, ADDR_WIDTH: byte target of the redirect.
REQ-008 Port mem_req, output, 1: read request valid.
REQ-009 Port mem_addr, output, ADDR_WIDTH: request address, always LINE_WIDTH/8-byte aligned.
REQ-010 Port mem_gnt, input, 1: request accepted this cycle.
REQ-011 Port mem_rvalid, input, 1: read data valid.
REQ-012 Port mem_rdata, input, [0:LINE_WIDTH-1]: read word; memory byte 0 at bits [0:7].
REQ-013 Port en_queue, output, 1: enqueue strobe to the downstream fetch queue.
REQ-014 Port in_count, output, int: valid bits in in_data.
REQ-015 Port in_data, output, [0:LINE_WIDTH-1]: fetched bytes, left-justified, first byte at bits [0:7].
REQ-016 Port empty_count, input, int: free bits reported by the queue.
REQ-017 Port queue_flush, output, 1: discard all queued bytes.

Function
REQ-018 States: REQ, WAIT, HOLD, DRAIN; exactly one outstanding memory request at any time.
REQ-019 REQ: mem_req=1, mem_addr=fetch_pc with low log2(LINE_WIDTH/8) bits cleared; mem_gnt -> WAIT, else stay.
REQ-020 mem_req SHALL be 0 in WAIT, HOLD and DRAIN.
REQ-021 WAIT: on mem_rvalid, with k = fetch_pc byte offset, capture mem_rdata shifted left by 8*k bits into hold_data, hold_count = LINE_WIDTH-8*k -> HOLD.
REQ-022 HOLD: en_queue = (empty_count >= LINE_WIDTH); in_data = hold_data; in_count = hold_count; when en_queue=1, fetch_pc <= aligned fetch_pc + LINE_WIDTH/8 -> REQ.
REQ-023 en_queue SHALL be 0 outside HOLD; in_count 0 and in_data all-zero outside HOLD.
REQ-024 Minimum latency with zero-wait memory and free queue: 3 cycles per word (REQ, WAIT, HOLD).
REQ-025 Address arithmetic wraps modulo 2^ADDR_WIDTH.
REQ-026 redirect has priority over all other transitions: fetch_pc <= redirect_pc; queue_flush=1 same cycle (combinational); en_queue=0 that cycle.
REQ-027 Redirect next state: REQ without mem_gnt -> REQ; REQ with mem_gnt -> DRAIN; WAIT without mem_rvalid -> DRAIN; WAIT with mem_rvalid -> REQ (data discarded); HOLD -> REQ; DRAIN -> DRAIN.
REQ-028 DRAIN: on mem_rvalid discard data -> REQ.
REQ-029 mem_rvalid in REQ or HOLD SHALL trigger an assertion failure.
REQ-030 Back-to-back redirects SHALL each update fetch_pc; the last one wins.

Reset
REQ-031 While reset=0: state REQ, fetch_pc=RESET_PC, hold_data=0, hold_count=0; mem_req=1, en_queue=0, in_count=0, queue_flush=0.
REQ-032 Reset asserted mid-transaction SHALL abandon any outstanding request; the memory model is reset in the same domain.

Structure
REQ-033 Shared package fetch_pkg: fetch_state_t enum {REQ, WAIT, HOLD, DRAIN}, LINE_BYTES constant, byte-offset width constant.
REQ-034 One sub-module, fetch_aligner: combinational left shift of mem_rdata by byte offset and valid-bit count.
REQ-035 Top module contains FSM, fetch_pc and hold registers only.

Verification
REQ-036 RESET_PC=0x1000, zero-wait memory, empty_count=256 -> mem_addr 0x1000, 0x1008, 0x1010 each 3 cycles apart; in_count=64 each.
REQ-037 Redirect to 0x2003 -> queue_flush pulse, next mem_addr=0x2000, in_count=40, in_data[0:7]=memory byte 0x2003; following mem_addr=0x2008.
REQ-038 empty_count=32 in HOLD for 5 cycles then 64 -> en_queue stays 0 for 5 cycles, data unchanged, single en_queue pulse.
REQ-039 Redirect in WAIT, rvalid 4 cycles later -> that data never enqueued; next mem_req only after rvalid, at redirect target.
REQ-040 Fetch at 0xFFFF_FFFF_FFFF_FFF8 -> next mem_addr 0x0 (wrap).
REQ-041 reset=0 asynchronously during WAIT -> outputs at reset values before the next clock edge; fetch restarts at RESET_PC.

Source files
------------

// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch unit.
package fetch_pkg;

  typedef enum logic [1:0] {REQ, WAIT, HOLD, DRAIN} fetch_state_t;

  localparam int unsigned LINE_BYTES = 8;
  localparam int unsigned OFF_W      = $clog2(LINE_BYTES);

  // Byte-offset width for a given line width (line must be at least 2 bytes).
  function automatic int unsigned off_width(input int unsigned line_width);
    return $clog2(line_width / 8);
  endfunction

endpackage

// File: rtl/fetch_aligner.sv
// Left-justifies a fetched memory word at the fetch byte offset and reports valid bits.
module fetch_aligner
  import fetch_pkg::*;
#(
  parameter int unsigned LINE_WIDTH = LINE_BYTES * 8,
  parameter int unsigned OW         = off_width(LINE_WIDTH)
) (
  input  logic [0:LINE_WIDTH-1] i_rdata,
  input  logic [OW-1:0]         i_offset,
  output logic [0:LINE_WIDTH-1] o_data,
  output int                    o_count
);

  // Bit 0 is the MSB, so a left shift moves byte k up to bits [0:7].
  assign o_data  = i_rdata << (8 * int'(i_offset));
  assign o_count = int'(LINE_WIDTH) - 8 * int'(i_offset);

endmodule

// File: rtl/fetch_unit.sv
// Fetch FSM: one outstanding line request, holds the aligned word until the queue has room.
module fetch_unit
  import fetch_pkg::*;
#(
  parameter int unsigned           ADDR_WIDTH = 64,
  parameter int unsigned           LINE_WIDTH = LINE_BYTES * 8,
  parameter logic [ADDR_WIDTH-1:0] RESET_PC   = '0
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  redirect,
  input  logic [ADDR_WIDTH-1:0] redirect_pc,
  output logic                  mem_req,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  input  logic                  mem_gnt,
  input  logic                  mem_rvalid,
  input  logic [0:LINE_WIDTH-1] mem_rdata,
  output logic                  en_queue,
  output int                    in_count,
  output logic [0:LINE_WIDTH-1] in_data,
  input  int                    empty_count,
  output logic                  queue_flush
);

  localparam int unsigned LB = LINE_WIDTH / 8;
  localparam int unsigned OW = off_width(LINE_WIDTH);

  fetch_state_t          r_state;
  logic [ADDR_WIDTH-1:0] r_pc;
  logic [0:LINE_WIDTH-1] r_hold_data;
  int                    r_hold_count;

  logic [ADDR_WIDTH-1:0] w_pc_aligned;
  logic [0:LINE_WIDTH-1] w_aligned_data;
  int                    w_aligned_count;
  logic                  w_hold;

  assign w_pc_aligned = {r_pc[ADDR_WIDTH-1:OW], {OW{1'b0}}};
  assign w_hold       = (r_state == HOLD);

  fetch_aligner #(
    .LINE_WIDTH(LINE_WIDTH),
    .OW        (OW)
  ) u_aligner (
    .i_rdata (mem_rdata),
    .i_offset(r_pc[OW-1:0]),
    .o_data  (w_aligned_data),
    .o_count (w_aligned_count)
  );

  assign mem_req     = (r_state == REQ);
  assign mem_addr    = w_pc_aligned;
  assign en_queue    = w_hold && !redirect && (empty_count >= int'(LINE_WIDTH));
  assign in_data     = w_hold ? r_hold_data : '0;
  assign in_count    = w_hold ? r_hold_count : 0;
  assign queue_flush = redirect && reset;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state      <= REQ;
      r_pc         <= RESET_PC;
      r_hold_data  <= '0;
      r_hold_count <= 0;
    end else if (redirect) begin
      r_pc <= redirect_pc;
      // A request still in flight must be drained before a new one may issue.
      unique case (r_state)
        REQ:         r_state <= mem_gnt ? DRAIN : REQ;
        WAIT, DRAIN: r_state <= mem_rvalid ? REQ : DRAIN;
        HOLD:        r_state <= REQ;
        default:     r_state <= REQ;
      endcase
    end else begin
      unique case (r_state)
        REQ: if (mem_gnt) r_state <= WAIT;
        WAIT: begin
          if (mem_rvalid) begin
            r_hold_data  <= w_aligned_data;
            r_hold_count <= w_aligned_count;
            r_state      <= HOLD;
          end
        end
        HOLD: begin
          if (en_queue) begin
            r_pc    <= w_pc_aligned + ADDR_WIDTH'(LB);
            r_state <= REQ;
          end
        end
        DRAIN: if (mem_rvalid) r_state <= REQ;
        default: r_state <= REQ;
      endcase
    end
  end

  // Read data may only return while a request is outstanding.
  assert property (@(posedge clk) disable iff (!reset)
                   mem_rvalid |-> (r_state == WAIT || r_state == DRAIN));

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: directed vector table, async reset sequence, randomized model run.
module tb_fetch_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic        redirect;
  logic [63:0] redirect_pc;
  logic        mem_req;
  logic [63:0] mem_addr;
  logic        mem_gnt;
  logic        mem_rvalid;
  logic [0:63] mem_rdata;
  logic        en_queue;
  int          in_count;
  logic [0:63] in_data;
  int          empty_count;
  logic        queue_flush;

  int checks = 0;
  int failures = 0;

  fetch_unit #(
    .ADDR_WIDTH(64),
    .LINE_WIDTH(64),
    .RESET_PC  (64'h1000)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .redirect   (redirect),
    .redirect_pc(redirect_pc),
    .mem_req    (mem_req),
    .mem_addr   (mem_addr),
    .mem_gnt    (mem_gnt),
    .mem_rvalid (mem_rvalid),
    .mem_rdata  (mem_rdata),
    .en_queue   (en_queue),
    .in_count   (in_count),
    .in_data    (in_data),
    .empty_count(empty_count),
    .queue_flush(queue_flush)
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] mem_byte(input logic [63:0] a);
    return (a[7:0] * 8'd3) ^ a[15:8] ^ a[63:56] ^ 8'h5A;
  endfunction

  function automatic logic [0:63] mem_word(input logic [63:0] a);
    logic [0:63] w;
    for (int i = 0; i < 8; i++) w[8*i +: 8] = mem_byte(a + 64'(i));
    return w;
  endfunction

  // Bytes from the fetch address to the end of its line, left-justified.
  function automatic logic [0:63] exp_line(input logic [63:0] pc);
    logic [0:63] d;
    int          off;
    d   = '0;
    off = int'(pc[2:0]);
    for (int i = 0; i < 8 - off; i++) d[8*i +: 8] = mem_byte(pc + 64'(i));
    return d;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  typedef struct {
    bit          redir;
    logic [63:0] rpc;
    bit          gnt;
    bit          rv;
    int          empty;
    bit          e_req;
    logic [63:0] e_addr;
    bit          e_en;
    int          e_cnt;
    bit          e_flush;
    bit          chk_b0;
    logic [63:0] b0_addr;
  } vec_t;

  function automatic vec_t mk(bit redir, logic [63:0] rpc, bit gnt, bit rv, int empty, bit e_req,
                              logic [63:0] e_addr, bit e_en, int e_cnt, bit e_flush, bit chk_b0,
                              logic [63:0] b0_addr);
    vec_t v;
    v.redir = redir; v.rpc = rpc; v.gnt = gnt; v.rv = rv; v.empty = empty;
    v.e_req = e_req; v.e_addr = e_addr; v.e_en = e_en; v.e_cnt = e_cnt;
    v.e_flush = e_flush; v.chk_b0 = chk_b0; v.b0_addr = b0_addr;
    return v;
  endfunction

  localparam logic [63:0] TOP8 = 64'hFFFF_FFFF_FFFF_FFF8;

  vec_t        tbl[$];
  logic [63:0] last_gnt = '0;

  // Reference model state (transaction level)
  logic [63:0] m_pc;
  bit          m_busy, m_stale, m_have;
  logic [63:0] m_cap;
  // Memory responder state
  bit          mbusy;
  logic [63:0] maddr;
  int          mcnt;
  int          n_enq;

  initial begin
    reset = 1'b0; redirect = 1'b0; redirect_pc = '0; mem_gnt = 1'b0; mem_rvalid = 1'b0;
    mem_rdata = '0; empty_count = 0;
    repeat (2) @(negedge clk);
    #1;
    chk("rst_req", 64'(mem_req), 64'd1);
    chk("rst_addr", mem_addr, 64'h1000);
    chk("rst_en", 64'(en_queue), 64'd0);
    chk("rst_cnt", 64'(in_count), 64'd0);
    chk("rst_flush", 64'(queue_flush), 64'd0);
    chk("rst_data", 64'(in_data), 64'd0);
    @(negedge clk);
    reset = 1'b1;

    //         redir rpc        g  rv empty req addr        en cnt fl b0 b0addr
    tbl.push_back(mk(0, 0,         1, 0, 256, 1, 64'h1000, 0, 0,  0, 0, 0));
    tbl.push_back(mk(0, 0,         0, 1, 256, 0, 0,        0, 0,  0, 0, 0));
    tbl.push_back(mk(0, 0,         0, 0, 256, 0, 0,        1, 64, 0, 1, 64'h1000));
    tbl.push_back(mk(0, 0,         1, 0, 256, 1, 64'h1008, 0, 0,  0, 0, 0));
    tbl.push_back(mk(0, 0,         0, 1, 256, 0, 0,        0, 0,  0, 0, 0));
    tbl.push_back(mk(0, 0,         0, 0, 256, 0, 0,        1, 64, 0, 1, 64'h1008));
    tbl.push_back(mk(0, 0,         1, 0, 256, 1, 64'h1010, 0, 0,  0, 0, 0));
    tbl.push_back(mk(0, 0,         0, 1, 256, 0, 0,        0, 0,  0, 0, 0));
    for (int i = 0; i < 5; i++)
      tbl.push_back(mk(0, 0,       0, 0, 32,  0, 0,        0, 64, 0, 1, 64'h1010));
    tbl.push_back(mk(0, 0,         0, 0, 64,  0, 0,        1, 64, 0, 1, 64'h1010));
    tbl.push_back(mk(1, 64'h2003,  0, 0, 256, 1, 64'h1018, 0, 0,  1, 0, 0));
    tbl.push_back(mk(0, 0,         1, 0, 256, 1, 64'h2000, 0, 0,  0, 0, 0));
    tbl.push_back(mk(0, 0,         0, 1, 256, 0, 0,        0, 0,  0, 0, 0));
    tbl.push_back(mk(0, 0,         0, 0, 256, 0, 0,        1, 40, 0, 1, 64'h2003));
    tbl.push_back(mk(0, 0,         1, 0, 256, 1, 64'h2008, 0, 0,  0, 0, 0));
    tbl.push_back(mk(0, 0,         0, 1, 256, 0, 0,        0, 0,  0, 0, 0));
    tbl.push_back(mk(0, 0,         0, 0, 64,  0, 0,        1, 64, 0, 1, 64'h2008));
    tbl.push_back(mk(0, 0,         1, 0, 256, 1, 64'h2010, 0, 0,  0, 0, 0));
    tbl.push_back(mk(1, 64'h3000,  0, 0, 256, 0, 0,        0, 0,  1, 0, 0));
    for (int i = 0; i < 3; i++)
      tbl.push_back(mk(0, 0,       0, 0, 256, 0, 0,        0, 0,  0, 0, 0));
    tbl.push_back(mk(0, 0,         0, 1, 256, 0, 0,        0, 0,  0, 0, 0));
    tbl.push_back(mk(0, 0,         0, 0, 256, 1, 64'h3000, 0, 0,  0, 0, 0));
    tbl.push_back(mk(0, 0,         1, 0, 256, 1, 64'h3000, 0, 0,  0, 0, 0));
    tbl.push_back(mk(0, 0,         0, 1, 256, 0, 0,        0, 0,  0, 0, 0));
    tbl.push_back(mk(0, 0,         0, 0, 256, 0, 0,        1, 64, 0, 1, 64'h3000));
    tbl.push_back(mk(1, 64'h4000,  0, 0, 256, 1, 64'h3008, 0, 0,  1, 0, 0));
    tbl.push_back(mk(1, 64'h5008,  0, 0, 256, 1, 64'h4000, 0, 0,  1, 0, 0));
    tbl.push_back(mk(0, 0,         1, 0, 256, 1, 64'h5008, 0, 0,  0, 0, 0));
    tbl.push_back(mk(0, 0,         0, 1, 256, 0, 0,        0, 0,  0, 0, 0));
    tbl.push_back(mk(0, 0,         0, 0, 256, 0, 0,        1, 64, 0, 1, 64'h5008));
    tbl.push_back(mk(1, TOP8,      0, 0, 256, 1, 64'h5010, 0, 0,  1, 0, 0));
    tbl.push_back(mk(0, 0,         1, 0, 256, 1, TOP8,     0, 0,  0, 0, 0));
    tbl.push_back(mk(0, 0,         0, 1, 256, 0, 0,        0, 0,  0, 0, 0));
    tbl.push_back(mk(0, 0,         0, 0, 256, 0, 0,        1, 64, 0, 1, TOP8));
    tbl.push_back(mk(0, 0,         0, 0, 256, 1, 64'h0,    0, 0,  0, 0, 0));
    tbl.push_back(mk(0, 0,         1, 0, 256, 1, 64'h0,    0, 0,  0, 0, 0));

    foreach (tbl[n]) begin
      @(negedge clk);
      redirect    = tbl[n].redir;
      redirect_pc = tbl[n].rpc;
      mem_gnt     = tbl[n].gnt;
      mem_rvalid  = tbl[n].rv;
      mem_rdata   = mem_word(last_gnt);
      empty_count = tbl[n].empty;
      #1;
      chk($sformatf("v%0d_req", n), 64'(mem_req), 64'(tbl[n].e_req));
      if (tbl[n].e_req) chk($sformatf("v%0d_addr", n), mem_addr, tbl[n].e_addr);
      chk($sformatf("v%0d_en", n), 64'(en_queue), 64'(tbl[n].e_en));
      chk($sformatf("v%0d_cnt", n), 64'(in_count), 64'(tbl[n].e_cnt));
      chk($sformatf("v%0d_flush", n), 64'(queue_flush), 64'(tbl[n].e_flush));
      if (tbl[n].chk_b0)
        chk($sformatf("v%0d_byte0", n), 64'(in_data[0:7]), 64'(mem_byte(tbl[n].b0_addr)));
      if (mem_req && mem_gnt) last_gnt = mem_addr;
    end

    // DUT now waits for data; pull reset between clock edges.
    @(negedge clk);
    mem_gnt = 1'b0; mem_rvalid = 1'b0; redirect = 1'b1; redirect_pc = 64'h7000;
    #1 reset = 1'b0;
    #1;
    chk("arst_req", 64'(mem_req), 64'd1);
    chk("arst_addr", mem_addr, 64'h1000);
    chk("arst_en", 64'(en_queue), 64'd0);
    chk("arst_cnt", 64'(in_count), 64'd0);
    chk("arst_flush", 64'(queue_flush), 64'd0);
    redirect = 1'b0;
    @(negedge clk);
    reset = 1'b1;

    m_pc = 64'h1000; m_busy = 0; m_stale = 0; m_have = 0; m_cap = '0;
    mbusy = 0; maddr = '0; mcnt = 0; n_enq = 0;
    for (int c = 0; c < 3000; c++) begin
      bit          e_req, e_en, issued;
      int          e_cnt;
      logic [0:63] e_data;
      int          pick;
      @(negedge clk);
      redirect    = ($urandom_range(19) == 0);
      redirect_pc = ($urandom_range(3) == 0) ? (64'hFFFF_FFFF_FFFF_FFF0 | 64'($urandom_range(15)))
                                             : {$urandom, $urandom};
      mem_gnt     = ($urandom_range(3) != 0);
      mem_rvalid  = mbusy && (mcnt == 0);
      mem_rdata   = mem_rvalid ? mem_word(maddr) : {$urandom, $urandom};
      pick        = $urandom_range(5);
      empty_count = (pick == 0) ? 0 : (pick == 1) ? 32 : (pick == 2) ? 63 :
                    (pick == 3) ? 64 : (pick == 4) ? 100 : 256;
      #1;
      e_req  = !m_busy && !m_have;
      e_en   = m_have && !redirect && (empty_count >= 64);
      e_cnt  = m_have ? 64 - 8 * int'(m_cap[2:0]) : 0;
      e_data = m_have ? exp_line(m_cap) : '0;
      chk("rnd_req", 64'(mem_req), 64'(e_req));
      if (e_req) chk("rnd_addr", mem_addr, {m_pc[63:3], 3'b000});
      chk("rnd_en", 64'(en_queue), 64'(e_en));
      chk("rnd_cnt", 64'(in_count), 64'(e_cnt));
      chk("rnd_data", 64'(in_data), 64'(e_data));
      chk("rnd_flush", 64'(queue_flush), 64'(redirect));

      issued = e_req && mem_gnt;
      if (redirect) begin
        m_pc   = redirect_pc;
        m_have = 0;
        if (m_busy && mem_rvalid) m_busy = 0;
        if (issued) m_busy = 1;
        m_stale = m_busy;
      end else begin
        if (m_busy && mem_rvalid) begin
          if (!m_stale) begin
            m_have = 1;
            m_cap  = m_pc;
          end
          m_busy  = 0;
          m_stale = 0;
        end
        if (issued) begin
          m_busy  = 1;
          m_stale = 0;
        end
        if (e_en) begin
          m_have = 0;
          m_pc   = {m_pc[63:3], 3'b000} + 64'd8;
        end
      end

      if (en_queue) n_enq++;
      if (mem_rvalid) mbusy = 0;
      if (mem_req && mem_gnt) begin
        mbusy = 1;
        maddr = mem_addr;
        mcnt  = $urandom_range(3);
      end else if (mbusy && !mem_rvalid) begin
        mcnt--;
      end
    end
    checks++;
    if (n_enq == 0) begin
      failures++;
      $display("FAIL rnd_progress: got %0d enqueues required at least 1", n_enq);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
